// File: rtl/mc_main_control_fsm.sv
// Main control FSM for the multi-cycle MIPS core.
// Sequences fetch/decode/execute/memory/writeback and drives datapath controls.
module mc_main_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_BNE   = 6'b000101,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       BranchNE,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALU_Op,
  output logic [1:0] PCSrc,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  state_e state_q, state_d;

  logic       iord_c, irwrite_c, pcwrite_c, branch_c, branchne_c;
  logic       memwrite_c, regwrite_c, regdst_c, memtoreg_c, alusrca_c;
  logic [1:0] alusrcb_c, aluop_c, pcsrc_c;
  logic       illegal_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    iord_c     = 1'b0;
    irwrite_c  = 1'b0;
    pcwrite_c  = 1'b0;
    branch_c   = 1'b0;
    branchne_c = 1'b0;
    memwrite_c = 1'b0;
    regwrite_c = 1'b0;
    regdst_c   = 1'b0;
    memtoreg_c = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = 2'b00;
    aluop_c    = 2'b00;
    pcsrc_c    = 2'b00;
    illegal_c  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb_c = 2'b01;
        irwrite_c = mem_ready;
        pcwrite_c = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALU precomputes the branch target into ALUOut
        alusrcb_c = 2'b11;
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)            state_d = S_EXECUTE;
        else if (opcode == OP_BEQ ||
                 opcode == OP_BNE)              state_d = S_BRANCH;
        else if (opcode == OP_ADDI)             state_d = S_ADDIEX;
        else if (opcode == OP_J)                state_d = S_JUMP;
        else                                    illegal_c = 1'b1;
      end
      S_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        if (opcode == OP_LW)      state_d = S_MEMREAD;
        else if (opcode == OP_SW) state_d = S_MEMWRITE;
      end
      S_MEMREAD: begin
        iord_c  = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        memtoreg_c = 1'b1;
        regwrite_c = 1'b1;
      end
      S_MEMWRITE: begin
        iord_c     = 1'b1;
        memwrite_c = 1'b1;
        state_d    = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        alusrca_c = 1'b1;
        aluop_c   = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        regdst_c   = 1'b1;
        regwrite_c = 1'b1;
      end
      S_BRANCH: begin
        alusrca_c  = 1'b1;
        aluop_c    = 2'b01;
        pcsrc_c    = 2'b01;
        branch_c   = 1'b1;
        branchne_c = (opcode == OP_BNE);
      end
      S_ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: regwrite_c = 1'b1;
      S_JUMP: begin
        pcsrc_c   = 2'b10;
        pcwrite_c = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset blanks every output combinationally, so an abandoned instruction writes nothing
  assign IorD       = ~rst & iord_c;
  assign IRWrite    = ~rst & irwrite_c;
  assign PCWrite    = ~rst & pcwrite_c;
  assign Branch     = ~rst & branch_c;
  assign BranchNE   = ~rst & branchne_c;
  assign MemWrite   = ~rst & memwrite_c;
  assign RegWrite   = ~rst & regwrite_c;
  assign RegDst     = ~rst & regdst_c;
  assign MemtoReg   = ~rst & memtoreg_c;
  assign ALUSrcA    = ~rst & alusrca_c;
  assign ALUSrcB    = rst ? 2'b00 : alusrcb_c;
  assign ALU_Op     = rst ? 2'b00 : aluop_c;
  assign PCSrc      = rst ? 2'b00 : pcsrc_c;
  assign illegal_op = ~rst & illegal_c;
  assign state_dbg  = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_mc_main_control_fsm.sv
// Scoreboard bench for mc_main_control_fsm: per-instruction step model,
// randomized opcodes and memory stalls, monitor compares every cycle.
module tb_mc_main_control_fsm;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] BNE   = 6'b000101;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] JMP   = 6'b000010;

  typedef struct packed {
    logic       iord, irw, pcw, br, brne, memw, regw, regdst, m2r, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       ill;
    logic [3:0] st;
  } out_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       IorD, IRWrite, PCWrite, Branch, BranchNE, MemWrite;
  logic       RegWrite, RegDst, MemtoReg, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALU_Op, PCSrc;
  logic [3:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  out_t exp_q[$];

  mc_main_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch),
    .BranchNE(BranchNE), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALU_Op(ALU_Op), .PCSrc(PCSrc),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic out_t actual();
    return {IorD, IRWrite, PCWrite, Branch, BranchNE, MemWrite, RegWrite,
            RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALU_Op, PCSrc,
            illegal_op, state_dbg};
  endfunction

  function automatic bit legal(logic [5:0] op);
    return op == RTYPE || op == LW || op == SW || op == BEQ ||
           op == BNE || op == ADDI || op == JMP;
  endfunction

  // Expected outputs for a cycle spent in the given state
  function automatic out_t exp_out(int st, logic [5:0] op, logic mr);
    out_t o = '0;
    o.st = st[3:0];
    case (st)
      0:  begin o.srcb = 2'b01; o.irw = mr; o.pcw = mr; end
      1:  begin o.srcb = 2'b11; o.ill = !legal(op); end
      2:  begin o.srca = 1'b1; o.srcb = 2'b10; end
      3:  o.iord = 1'b1;
      4:  begin o.m2r = 1'b1; o.regw = 1'b1; end
      5:  begin o.iord = 1'b1; o.memw = 1'b1; end
      6:  begin o.srca = 1'b1; o.aluop = 2'b10; end
      7:  begin o.regdst = 1'b1; o.regw = 1'b1; end
      8:  begin
            o.srca = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01;
            o.br = 1'b1; o.brne = (op == BNE);
          end
      9:  begin o.srca = 1'b1; o.srcb = 2'b10; end
      10: o.regw = 1'b1;
      11: begin o.pcsrc = 2'b10; o.pcw = 1'b1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic check(string name, out_t act, out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h required %h", name, $time, act, exp);
    end
  endtask

  task automatic check_bit(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b required %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    out_t a, e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = actual();
      check("cycle_outputs", a, e);
      check_bit("pcwrite_branch_exclusive", a.pcw & a.br, 1'b0);
      check_bit("regwrite_memwrite_exclusive", a.regw & a.memw, 1'b0);
    end
  end

  task automatic drive(logic r, logic [5:0] op, logic mr, out_t e);
    @(negedge clk);
    rst = r;
    opcode = op;
    mem_ready = mr;
    exp_q.push_back(e);
  endtask

  // Instruction-level model: the state visits each opcode class makes
  task automatic run_instr(logic [5:0] op, int fs, int ms);
    int steps[$];
    logic [5:0] cur;
    logic mr;
    int n;
    steps = '{0, 1};
    if (op == RTYPE)                 steps.push_back(6);
    if (op == RTYPE)                 steps.push_back(7);
    if (op == LW || op == SW)        steps.push_back(2);
    if (op == LW)                    steps.push_back(3);
    if (op == LW)                    steps.push_back(4);
    if (op == SW)                    steps.push_back(5);
    if (op == BEQ || op == BNE)      steps.push_back(8);
    if (op == ADDI)                  steps.push_back(9);
    if (op == ADDI)                  steps.push_back(10);
    if (op == JMP)                   steps.push_back(11);
    foreach (steps[k]) begin
      int st = steps[k];
      n = (st == 0) ? fs : (st == 3 || st == 5) ? ms : 0;
      for (int i = 0; i <= n; i++) begin
        if (st == 0 || st == 3 || st == 5) mr = (i == n);
        else                               mr = 1'($urandom);
        cur = (st == 0) ? 6'($urandom) : op;
        drive(1'b0, cur, mr, exp_out(st, cur, mr));
      end
    end
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] op;
    case ($urandom_range(0, 7))
      0: op = RTYPE;
      1: op = LW;
      2: op = SW;
      3: op = BEQ;
      4: op = BNE;
      5: op = ADDI;
      6: op = JMP;
      default: begin
        op = 6'($urandom);
        while (legal(op)) op = 6'($urandom);
      end
    endcase
    return op;
  endfunction

  initial begin
    rst = 1'b1;
    opcode = 6'd0;
    mem_ready = 1'b0;
    drive(1'b1, 6'd0, 1'b1, '0);
    drive(1'b1, 6'd0, 1'b1, '0);
    drive(1'b0, 6'd0, 1'b0, exp_out(0, 6'd0, 1'b0));
    run_instr(RTYPE, 0, 0);
    run_instr(LW, 0, 3);
    run_instr(SW, 0, 0);
    run_instr(BNE, 0, 0);
    run_instr(BEQ, 0, 0);
    run_instr(JMP, 0, 0);
    run_instr(6'b111111, 2, 0);
    run_instr(ADDI, 1, 0);
    // Reset asserted in the middle of EXECUTE
    drive(1'b0, 6'd7, 1'b1, exp_out(0, 6'd7, 1'b1));
    drive(1'b0, RTYPE, 1'b1, exp_out(1, RTYPE, 1'b1));
    drive(1'b0, RTYPE, 1'b1, exp_out(6, RTYPE, 1'b1));
    #3 rst = 1'b1;
    #1 check("async_reset_outputs", actual(), '0);
    drive(1'b1, RTYPE, 1'b1, '0);
    drive(1'b0, RTYPE, 1'b0, exp_out(0, RTYPE, 1'b0));
    for (int i = 0; i < 300; i++)
      run_instr(rand_op(), $urandom_range(0, 3), $urandom_range(0, 3));
    @(negedge clk);
    #4;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending required 0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
